// File: rtl/sblk_act_loader.sv
// sblk_act_loader: instruction-driven activation loader; optional perf counters via SBLK_ACT_LOADER_PERF_EN
module sblk_act_loader #(
  parameter int N_TILE      = 4,
  parameter int WID_ACT     = 16,
  parameter int N_PACK      = 2,
  parameter int N_BANK      = 2,
  parameter int WID_ACTADDR = 6,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TP = 2,
  parameter int WID_INST_LP = 3,
  parameter int WID_INST    = WID_INST_TN + WID_INST_TP + WID_INST_LP
) (
  input  logic                                  clk_l,
  input  logic                                  rst,
  input  logic [WID_INST-1:0]                   inst_data,
  input  logic                                  inst_en,
  output logic                                  inst_err,
  output logic                                  act_data_in_req,
  input  logic                                  act_data_in_vld,
  input  logic [N_PACK*WID_ACT-1:0]             act_data_in,
  output logic [N_TILE-1:0]                     act_wr_en,
  output logic [$clog2(N_BANK)+WID_ACTADDR-1:0] act_wr_addr,
  output logic [N_PACK*WID_ACT-1:0]             act_wr_data,
  output logic [N_BANK-1:0]                     bank_full,
  input  logic [N_BANK-1:0]                     bank_rel,
  output logic                                  status_sblk,
  output logic [31:0]                           perf_stall_cnt,
  output logic [31:0]                           perf_bankwait_cnt
);
  localparam int BW = $clog2(N_BANK);
  localparam int TW = N_TILE > 1 ? $clog2(N_TILE) : 1;
  localparam int PW = WID_INST_TN + WID_INST_TP;
  typedef enum logic [1:0] {IDLE, WAIT_BANK, REQ, DONE} state_t;
  state_t                   state_q;
  logic [WID_INST_TN-1:0]   tn_q;
  logic [WID_INST_TP-1:0]   tp_q;
  logic [WID_INST_LP-1:0]   lp_q, lp_cnt_q, lp_nxt;
  logic [BW-1:0]            cur_q;
  logic [TW-1:0]            tile_q;
  logic [WID_ACTADDR-1:0]   word_q;
  logic                     inst_err_q;
  logic [N_TILE-1:0]        wr_en_q;
  logic [BW+WID_ACTADDR-1:0] wr_addr_q;
  logic [N_PACK*WID_ACT-1:0] wr_data_q;
  logic [N_BANK-1:0]        bank_full_q, bank_full_d;
  logic [WID_INST_TN-1:0]   in_tn;
  logic [WID_INST_TP-1:0]   in_tp;
  logic [WID_INST_LP-1:0]   in_lp;
  logic [PW-1:0]            words;
  logic                     zero_f, accept, last_tile, last_word, last_beat;
  assign in_tn           = inst_data[WID_INST_TN-1:0];
  assign in_tp           = inst_data[PW-1:WID_INST_TN];
  assign in_lp           = inst_data[WID_INST-1:PW];
  assign zero_f          = ~|in_tn | ~|in_tp | ~|in_lp;
  assign words           = PW'(tn_q) * PW'(tp_q);
  assign accept          = state_q == REQ && act_data_in_vld;
  assign last_tile       = 32'(tile_q) == N_TILE - 1;
  assign last_word       = 32'(word_q) == 32'(words) - 32'd1;
  assign last_beat       = last_tile && last_word;
  assign lp_nxt          = lp_cnt_q + WID_INST_LP'(1);
  assign bank_full_d     = (bank_full_q & ~bank_rel) | (state_q == DONE ? N_BANK'(1) << cur_q : '0);
  assign inst_err        = inst_err_q;
  assign act_data_in_req = state_q == REQ;
  assign status_sblk     = state_q != IDLE;
  assign act_wr_en       = wr_en_q;
  assign act_wr_addr     = wr_addr_q;
  assign act_wr_data     = wr_data_q;
  assign bank_full       = bank_full_q;
  // loader FSM, beat sequencing, bank bookkeeping and registered write port
  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q     <= IDLE;
      tn_q        <= '0;
      tp_q        <= '0;
      lp_q        <= '0;
      lp_cnt_q    <= '0;
      cur_q       <= '0;
      tile_q      <= '0;
      word_q      <= '0;
      inst_err_q  <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bank_full_q <= '0;
    end else begin
      inst_err_q  <= inst_en && (state_q != IDLE || zero_f);
      wr_en_q     <= accept ? N_TILE'(1) << tile_q : '0;
      wr_addr_q   <= {cur_q, word_q};
      wr_data_q   <= act_data_in;
      bank_full_q <= bank_full_d;
      case (state_q)
        IDLE: if (inst_en && !zero_f) begin
          tn_q     <= in_tn;
          tp_q     <= in_tp;
          lp_q     <= in_lp;
          lp_cnt_q <= '0;
          tile_q   <= '0;
          word_q   <= '0;
          state_q  <= WAIT_BANK;
        end
        WAIT_BANK: if (!bank_full_q[cur_q]) state_q <= REQ;
        REQ: if (accept) begin
          tile_q <= last_tile ? '0 : tile_q + TW'(1);
          word_q <= last_tile ? (last_word ? '0 : word_q + WID_ACTADDR'(1)) : word_q;
          if (last_beat) state_q <= DONE;
        end
        DONE: begin
          cur_q    <= cur_q + BW'(1);
          lp_cnt_q <= lp_nxt;
          state_q  <= lp_nxt == lp_q ? IDLE : WAIT_BANK;
        end
      endcase
    end
  end
`ifdef SBLK_ACT_LOADER_PERF_EN
  logic [31:0] stall_q, bwait_q;
  logic        start;
  assign start             = state_q == IDLE && inst_en && !zero_f;
  assign perf_stall_cnt    = stall_q;
  assign perf_bankwait_cnt = bwait_q;
  // saturating stall and bank-wait counters, cleared when a new instruction starts
  always_ff @(posedge clk_l) begin
    if (rst || start) begin
      stall_q <= '0;
      bwait_q <= '0;
    end else begin
      if (state_q == REQ && !act_data_in_vld && ~&stall_q) stall_q <= stall_q + 32'd1;
      if (state_q == WAIT_BANK && ~&bwait_q) bwait_q <= bwait_q + 32'd1;
    end
  end
`else
  assign perf_stall_cnt    = '0;
  assign perf_bankwait_cnt = '0;
`endif
endmodule

// File: tb/tb_sblk_act_loader.sv
// tb_sblk_act_loader: directed bench for sblk_act_loader
module tb_sblk_act_loader;
  logic        clk_l = 1'b0, rst = 1'b1, inst_en = 1'b0, act_data_in_vld = 1'b0;
  logic [7:0]  inst_data = '0;
  logic [31:0] act_data_in = '0;
  logic [1:0]  bank_rel = '0;
  logic        inst_err, act_data_in_req, status_sblk;
  logic [3:0]  act_wr_en;
  logic [6:0]  act_wr_addr;
  logic [31:0] act_wr_data, perf_stall_cnt, perf_bankwait_cnt;
  logic [1:0]  bank_full;
  sblk_act_loader dut (
    .clk_l(clk_l), .rst(rst), .inst_data(inst_data), .inst_en(inst_en), .inst_err(inst_err),
    .act_data_in_req(act_data_in_req), .act_data_in_vld(act_data_in_vld), .act_data_in(act_data_in),
    .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
    .bank_full(bank_full), .bank_rel(bank_rel), .status_sblk(status_sblk),
    .perf_stall_cnt(perf_stall_cnt), .perf_bankwait_cnt(perf_bankwait_cnt)
  );
  always #5 clk_l = ~clk_l;
  typedef struct {logic [3:0] en; logic [6:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int tn; int tp; int lp; bit tog; int b0; logic [1:0] full;} vec_t;
  wr_t  cap[$];
  vec_t vt[4];
  int   pass_n = 0, tot_n = 0, err_cnt = 0, oh_bad = 0, beat_i = 0, stall_m = 0;
  bit   feed_on = 1'b0, feed_tog = 1'b0;
  // beat source: packed {2i+1, 2i}, optionally valid every other cycle
  always @(negedge clk_l) begin
    if (!feed_on) begin
      act_data_in_vld = 1'b0;
      beat_i = 0;
      stall_m = 0;
    end else begin
      act_data_in_vld = feed_tog ? !act_data_in_vld : 1'b1;
      act_data_in = {16'(2*beat_i+1), 16'(2*beat_i)};
      if (act_data_in_req && act_data_in_vld) beat_i++;
      else if (act_data_in_req) stall_m++;
    end
  end
  // write capture and error/one-hot observation
  always @(negedge clk_l) begin
    if (act_wr_en != 0) cap.push_back('{act_wr_en, act_wr_addr, act_wr_data});
    if (!$onehot0(act_wr_en)) oh_bad++;
    if (inst_err) err_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic check_writes(input int b0, input int bb);
    foreach (cap[w]) begin
      int i = w % bb;
      int l = w / bb;
      check($sformatf("write[%0d]", w), {cap[w].en, cap[w].addr, cap[w].data},
            {4'(1 << (i % 4)), 1'((b0 + l) % 2), 6'(i / 4), 16'(2*w+1), 16'(2*w)});
    end
  endtask
  task automatic issue(input int tn, input int tp, input int lp);
    @(negedge clk_l);
    inst_data = {3'(lp), 2'(tp), 3'(tn)};
    inst_en = 1'b1;
    @(negedge clk_l);
    inst_en = 1'b0;
  endtask
  task automatic release_all();
    @(negedge clk_l);
    bank_rel = 2'b11;
    @(negedge clk_l);
    bank_rel = 2'b00;
  endtask
  task automatic run(input vec_t v);
    int bb = v.tn * v.tp * 4;
    int t = 0, last_wr = -1, e0;
    release_all();
    cap.delete();
    feed_tog = v.tog;
    feed_on = 1'b1;
    e0 = err_cnt;
    issue(v.tn, v.tp, v.lp);
    while (status_sblk === 1'b1 && t < 2000) begin
      if (act_wr_en != 0) last_wr = t;
      @(negedge clk_l);
      t++;
    end
    check("run_timeout", 64'(t < 2000), 64'(1));
    check("status_fall_gap", 64'(t - last_wr), 64'(1));
    @(negedge clk_l);
    feed_on = 1'b0;
    check("beat_count", 64'(cap.size()), 64'(bb * v.lp));
    check("bank_full", 64'(bank_full), 64'(v.full));
    check("no_inst_err", 64'(err_cnt - e0), 64'(0));
    check_writes(v.b0, bb);
  endtask
  initial begin
    int t, e0;
    bit busy;
    vt[0] = '{2, 2, 1, 1'b0, 0, 2'b01};
    vt[1] = '{1, 1, 2, 1'b0, 1, 2'b11};
    vt[2] = '{3, 1, 1, 1'b1, 1, 2'b10};
    vt[3] = '{1, 2, 2, 1'b1, 0, 2'b11};
    repeat (3) @(negedge clk_l);
    check("rst_req", 64'(act_data_in_req), 64'(0));
    check("rst_status", 64'(status_sblk), 64'(0));
    check("rst_err", 64'(inst_err), 64'(0));
    check("rst_wr", {act_wr_en, act_wr_addr, act_wr_data}, 64'(0));
    check("rst_full", 64'(bank_full), 64'(0));
    check("rst_perf", {perf_stall_cnt, perf_bankwait_cnt}, 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) run(vt[k]);
    release_all();
    cap.delete();
    feed_tog = 1'b1;
    feed_on = 1'b1;
    e0 = err_cnt;
    busy = 1'b0;
    t = 0;
    issue(1, 2, 3);
    while (!(bank_full == 2'b11 && !act_data_in_req) && t < 1000) begin
      inst_en = 1'b0;
      if (!busy && cap.size() >= 3) begin
        inst_data = 8'hff;
        inst_en = 1'b1;
        busy = 1'b1;
      end
      @(negedge clk_l);
      t++;
    end
    inst_en = 1'b0;
    check("pp_fill_timeout", 64'(t < 1000), 64'(1));
    repeat (10) @(negedge clk_l);
    check("pp_wait_req", 64'(act_data_in_req), 64'(0));
    check("pp_wait_status", 64'(status_sblk), 64'(1));
    check("pp_wait_beats", 64'(cap.size()), 64'(16));
    check("pp_busy_err", 64'(err_cnt - e0), 64'(1));
`ifdef SBLK_ACT_LOADER_PERF_EN
    check("pp_bankwait", 64'(perf_bankwait_cnt >= 10), 64'(1));
`endif
    @(negedge clk_l);
    bank_rel = 2'b01;
    @(negedge clk_l);
    bank_rel = 2'b00;
    t = 0;
    while (status_sblk && t < 1000) begin
      @(negedge clk_l);
      t++;
    end
    check("pp_done_timeout", 64'(t < 1000), 64'(1));
    @(negedge clk_l);
    check("pp_beats", 64'(cap.size()), 64'(24));
    check("pp_full", 64'(bank_full), 64'(2'b11));
    check_writes(0, 8);
`ifdef SBLK_ACT_LOADER_PERF_EN
    check("pp_stall", 64'(perf_stall_cnt), 64'(stall_m));
`else
    check("perf_tied", {perf_stall_cnt, perf_bankwait_cnt}, 64'(0));
`endif
    feed_on = 1'b0;
    cap.delete();
    feed_tog = 1'b0;
    feed_on = 1'b1;
    @(negedge clk_l);
    inst_data = {3'd1, 2'd0, 3'd2};
    inst_en = 1'b1;
    @(negedge clk_l);
    inst_en = 1'b0;
    check("zero_err", 64'(inst_err), 64'(1));
    check("zero_status", 64'(status_sblk), 64'(0));
    @(negedge clk_l);
    check("zero_err_pulse", 64'(inst_err), 64'(0));
    repeat (5) @(negedge clk_l);
    check("zero_req", 64'(act_data_in_req), 64'(0));
    check("zero_no_write", 64'(cap.size()), 64'(0));
    feed_on = 1'b0;
    @(negedge clk_l);
    bank_rel = 2'b10;
    @(negedge clk_l);
    bank_rel = 2'b00;
    check("rel_bank1", 64'(bank_full), 64'(2'b01));
    cap.delete();
    feed_on = 1'b1;
    issue(2, 2, 1);
    t = 0;
    while (cap.size() < 7 && t < 500) begin
      @(negedge clk_l);
      t++;
    end
    check("mid_timeout", 64'(t < 500), 64'(1));
    rst = 1'b1;
    feed_on = 1'b0;
    @(negedge clk_l);
    rst = 1'b0;
    check("mid_req", 64'(act_data_in_req), 64'(0));
    check("mid_wr_en", 64'(act_wr_en), 64'(0));
    check("mid_full", 64'(bank_full), 64'(0));
    check("mid_status", 64'(status_sblk), 64'(0));
    check("mid_first_addr", 64'(cap.size() > 0 ? cap[0].addr : 7'h7f), 64'(7'h40));
    run('{1, 1, 1, 1'b0, 0, 2'b01});
    check("onehot_viol", 64'(oh_bad), 64'(0));
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
